// File: rtl/fetch_decode_queue_pkg.sv
// rtl/fetch_decode_queue_pkg.sv - shared widths and entry types for the fetch/decode queue
package fetch_decode_queue_pkg;

  localparam int INSTR_WIDTH = 32;
  localparam int PC_WIDTH    = 32;

  typedef struct packed {
    logic                xcpt_itlb_miss;
    logic                xcpt_bus_error;
    logic [PC_WIDTH-1:0] addr;
  } fetch_xcpt_t;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    pc;
    fetch_xcpt_t            xcpt;
  } fetch_queue_entry_t;

endpackage

// File: rtl/fetch_queue_ctrl.sv
// rtl/fetch_queue_ctrl.sv - read/write pointers, count and sticky overflow flag for the queue
module fetch_queue_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push_req,
  input  logic                       ready,
  output logic                       wr_en,
  output logic [$clog2(DEPTH)-1:0]   wr_ptr,
  output logic [$clog2(DEPTH)-1:0]   rd_ptr,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       valid,
  output logic                       full,
  output logic                       overflow_err
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic push;
  logic pop;
  logic ovf_set;

  // Handshake decode; a pop from full frees the slot the same-cycle push lands in.
  always_comb begin
    push    = push_req & ~flush;
    valid   = (count != '0) & ~flush;
    pop     = valid & ready;
    full    = (count == CW'(DEPTH));
    wr_en   = push & (~full | pop);
    ovf_set = push & full & ~pop;
  end

  // Pointers and count; flush clears them, DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr_en) - CW'(pop);
    end
  end

  // Overflow is sticky until reset so a fetch protocol violation is never lost.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       overflow_err <= 1'b0;
    else if (ovf_set) overflow_err <= 1'b1;
  end

endmodule

// File: rtl/fetch_decode_queue.sv
// rtl/fetch_decode_queue.sv - in-order instruction queue between fetch and decode
module fetch_decode_queue
  import fetch_decode_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     fetch_instr_valid,
  input  logic [INSTR_WIDTH-1:0]   fetch_instr_data,
  input  logic [PC_WIDTH-1:0]      fetch_instr_pc,
  input  fetch_xcpt_t              fetch_xcpt,
  output logic                     stall_fetch,
  output logic                     decode_instr_valid,
  output logic [INSTR_WIDTH-1:0]   decode_instr_data,
  output logic [PC_WIDTH-1:0]      decode_instr_pc,
  output fetch_xcpt_t              decode_xcpt,
  input  logic                     decode_ready,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     overflow_err
);

  localparam int PW = $clog2(DEPTH);

  fetch_queue_entry_t mem [DEPTH];
  fetch_queue_entry_t head;
  logic               wr_en;
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic               full;

  fetch_queue_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clock        (clock),
    .reset        (reset),
    .flush        (flush),
    .push_req     (fetch_instr_valid),
    .ready        (decode_ready),
    .wr_en        (wr_en),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .count        (occupancy),
    .valid        (decode_instr_valid),
    .full         (full),
    .overflow_err (overflow_err)
  );

  // Entry storage is intentionally not reset; validity comes only from the count.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr] <= '{instr: fetch_instr_data, pc: fetch_instr_pc, xcpt: fetch_xcpt};
    end
  end

  // Head slot drives decode directly; stall is from registered count only.
  always_comb begin
    head              = mem[rd_ptr];
    decode_instr_data = head.instr;
    decode_instr_pc   = head.pc;
    decode_xcpt       = head.xcpt;
    stall_fetch       = full;
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// tb/tb_fetch_decode_queue.sv - directed self-checking bench for fetch_decode_queue
module tb_fetch_decode_queue;
  import fetch_decode_queue_pkg::*;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   flush;
  logic                   fetch_instr_valid;
  logic [INSTR_WIDTH-1:0] fetch_instr_data;
  logic [PC_WIDTH-1:0]    fetch_instr_pc;
  fetch_xcpt_t            fetch_xcpt;
  logic                   stall_fetch;
  logic                   decode_instr_valid;
  logic [INSTR_WIDTH-1:0] decode_instr_data;
  logic [PC_WIDTH-1:0]    decode_instr_pc;
  fetch_xcpt_t            decode_xcpt;
  logic                   decode_ready;
  logic [2:0]             occupancy;
  logic                   overflow_err;

  int checks = 0;
  int failures = 0;

  fetch_decode_queue #(.DEPTH(4)) dut (
    .clock              (clock),
    .reset              (reset),
    .flush              (flush),
    .fetch_instr_valid  (fetch_instr_valid),
    .fetch_instr_data   (fetch_instr_data),
    .fetch_instr_pc     (fetch_instr_pc),
    .fetch_xcpt         (fetch_xcpt),
    .stall_fetch        (stall_fetch),
    .decode_instr_valid (decode_instr_valid),
    .decode_instr_data  (decode_instr_data),
    .decode_instr_pc    (decode_instr_pc),
    .decode_xcpt        (decode_xcpt),
    .decode_ready       (decode_ready),
    .occupancy          (occupancy),
    .overflow_err       (overflow_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic itlb);
    fetch_instr_valid = v;
    fetch_instr_pc    = pc;
    fetch_instr_data  = {16'hA5A5, pc[15:0]};
    fetch_xcpt        = '{xcpt_itlb_miss: itlb, xcpt_bus_error: 1'b0, addr: itlb ? pc : 32'h0};
  endtask

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    decode_ready = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    #12;
    chk("rst_valid", decode_instr_valid, 0);
    chk("rst_stall", stall_fetch, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_ovf", overflow_err, 0);
    reset = 1'b1;
    tick();

    // Fill to full with decode stalled, then drain in order.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h1000 + 32'(4 * i), 1'b0);
      tick();
      chk("fill_occ", occupancy, 64'(i + 1));
      chk("fill_stall", stall_fetch, (i == 3) ? 64'd1 : 64'd0);
    end
    drive(1'b0, 32'h0, 1'b0);
    decode_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", decode_instr_valid, 1);
      chk("drain_pc", decode_instr_pc, 64'(32'h1000 + 32'(4 * i)));
      chk("drain_data", decode_instr_data, 64'(32'hA5A51000 + 32'(4 * i)));
      chk("drain_stall", stall_fetch, (i == 0) ? 64'd1 : 64'd0);
      tick();
    end
    chk("drain_occ", occupancy, 0);
    chk("drain_empty", decode_instr_valid, 0);

    // Push into empty queue with decode ready: no bypass, visible next cycle.
    drive(1'b1, 32'h2000, 1'b0);
    chk("nobypass_valid", decode_instr_valid, 0);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    chk("lat_valid", decode_instr_valid, 1);
    chk("lat_pc", decode_instr_pc, 64'h2000);
    chk("lat_occ", occupancy, 1);
    tick();
    chk("lat_occ0", occupancy, 0);

    // Three entries then flush together with a push.
    decode_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h30A0 + 32'(4 * i), 1'b0);
      tick();
    end
    chk("preflush_occ", occupancy, 3);
    drive(1'b1, 32'h3000, 1'b0);
    flush = 1'b1;
    decode_ready = 1'b1;
    #1;
    chk("flush_mask", decode_instr_valid, 0);
    tick();
    flush = 1'b0;
    drive(1'b1, 32'h3100, 1'b0);
    chk("flush_occ", occupancy, 0);
    chk("flush_valid", decode_instr_valid, 0);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    chk("postflush_valid", decode_instr_valid, 1);
    chk("postflush_pc", decode_instr_pc, 64'h3100);
    tick();
    chk("postflush_occ", occupancy, 0);

    // Full queue with simultaneous pop and push.
    decode_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h4000 + 32'(4 * i), 1'b0);
      tick();
    end
    drive(1'b1, 32'h4010, 1'b0);
    decode_ready = 1'b1;
    tick();
    drive(1'b0, 32'h0, 1'b0);
    chk("fullpp_occ", occupancy, 4);
    chk("fullpp_stall", stall_fetch, 1);
    chk("fullpp_ovf", overflow_err, 0);
    for (int i = 0; i < 4; i++) begin
      chk("fullpp_pc", decode_instr_pc, 64'(32'h4004 + 32'(4 * i)));
      tick();
    end
    chk("fullpp_occ0", occupancy, 0);

    // Overflow on push without pop, then asynchronous reset.
    decode_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h6000 + 32'(4 * i), 1'b0);
      tick();
    end
    drive(1'b1, 32'h6FFF, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    chk("ovf_set", overflow_err, 1);
    chk("ovf_occ", occupancy, 4);
    chk("ovf_head", decode_instr_pc, 64'h6000);
    tick();
    chk("ovf_sticky", overflow_err, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_ovf", overflow_err, 0);
    chk("arst_occ", occupancy, 0);
    chk("arst_valid", decode_instr_valid, 0);
    chk("arst_stall", stall_fetch, 0);
    #2;
    reset = 1'b1;
    tick();

    // Exception flags ride along with their entry.
    drive(1'b1, 32'h5000, 1'b1);
    tick();
    drive(1'b1, 32'h5004, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    decode_ready = 1'b1;
    chk("xcpt_pc0", decode_instr_pc, 64'h5000);
    chk("xcpt_itlb0", decode_xcpt.xcpt_itlb_miss, 1);
    chk("xcpt_addr0", decode_xcpt.addr, 64'h5000);
    tick();
    chk("xcpt_pc1", decode_instr_pc, 64'h5004);
    chk("xcpt_itlb1", decode_xcpt.xcpt_itlb_miss, 0);
    tick();
    chk("xcpt_occ", occupancy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
